// File: rtl/sctag_vuad_errlog_pkg.sv
// rtl/sctag_vuad_errlog_pkg.sv - shared types and constants for the VUAD parity error logger
package sctag_vuad_errlog_pkg;

    localparam int SYN_VLD = 3;
    localparam int SYN_DRT = 2;
    localparam int SYN_USD = 1;
    localparam int SYN_ALC = 0;

    localparam int REC_IDX_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } errlog_state_t;

    typedef struct packed {
        logic [3:0]           syn;
        logic [REC_IDX_W-1:0] idx;
        logic                 vd;
        logic                 ua;
    } errlog_rec_t;

    function automatic logic syn_vd(input logic [3:0] s);
        return s[SYN_VLD] | s[SYN_DRT];
    endfunction

    function automatic logic syn_ua(input logic [3:0] s);
        return s[SYN_USD] | s[SYN_ALC];
    endfunction

endpackage

// File: rtl/sctag_vuad_errlog_cnt.sv
// rtl/sctag_vuad_errlog_cnt.sv - saturating event counter, cleared only by reset
module sctag_vuad_errlog_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sctag_vuad_errlog.sv
// rtl/sctag_vuad_errlog.sv - VUAD parity error classifier/logger; SCTAG_VUAD_ERRLOG_INJ_EN adds error injection
module sctag_vuad_errlog
    import sctag_vuad_errlog_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic [3:0]       vuad_syndrome_c9,
    input  logic             vuad_rd_vld_c9,
    input  logic [IDX_W-1:0] vuad_idx_c9,
`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
    input  logic             errinj_arm,
    input  logic [3:0]       errinj_mask,
`endif
    input  logic             csr_err_ack,
    output logic             errlog_req,
    output logic             errlog_vd_err,
    output logic             errlog_ua_err,
    output logic [3:0]       errlog_syndrome,
    output logic [IDX_W-1:0] errlog_idx,
    output logic             errlog_ovf,
    output logic [CNT_W-1:0] errlog_cnt,
    output logic             errlog_fatal
);

    logic [3:0] syn_eff;

`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
    logic       inj_armed;
    logic [3:0] inj_mask;

    // A fresh arm takes priority, so an arm coinciding with a read lands on a later read.
    always_ff @(posedge rclk) begin
        if (rst) begin
            inj_armed <= 1'b0;
            inj_mask  <= 4'b0;
        end else if (errinj_arm) begin
            inj_armed <= 1'b1;
            inj_mask  <= errinj_mask;
        end else if (inj_armed && vuad_rd_vld_c9) begin
            inj_armed <= 1'b0;
        end
    end

    assign syn_eff = vuad_syndrome_c9 ^ (inj_armed ? inj_mask : 4'b0);
`else
    assign syn_eff = vuad_syndrome_c9;
`endif

    logic             c10_vld;
    logic [3:0]       c10_syn;
    logic [IDX_W-1:0] c10_idx;

    always_ff @(posedge rclk) begin
        if (rst) begin
            c10_vld <= 1'b0;
            c10_syn <= 4'b0;
            c10_idx <= '0;
        end else begin
            c10_vld <= vuad_rd_vld_c9 & (|syn_eff);
            c10_syn <= syn_eff;
            c10_idx <= vuad_idx_c9;
        end
    end

    errlog_state_t state;
    errlog_rec_t   rec;
    errlog_rec_t   rec_new;

    always_comb begin
        rec_new     = '0;
        rec_new.syn = c10_syn;
        rec_new.idx = REC_IDX_W'(c10_idx);
        rec_new.vd  = syn_vd(c10_syn);
        rec_new.ua  = syn_ua(c10_syn);
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state      <= IDLE;
            rec        <= '0;
            errlog_req <= 1'b0;
            errlog_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c10_vld) begin
                        rec        <= rec_new;
                        errlog_ovf <= 1'b0;
                        errlog_req <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (csr_err_ack) begin
                        // Event arriving with the ack becomes the next record immediately.
                        if (c10_vld) begin
                            rec        <= rec_new;
                            errlog_ovf <= 1'b0;
                        end else begin
                            errlog_req <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (c10_vld) begin
                        errlog_ovf <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    errlog_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            errlog_fatal <= 1'b0;
        end else if (c10_vld && syn_vd(c10_syn)) begin
            errlog_fatal <= 1'b1;
        end
    end

    sctag_vuad_errlog_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (rclk),
        .rst (rst),
        .inc (c10_vld),
        .cnt (errlog_cnt)
    );

    assign errlog_vd_err   = rec.vd;
    assign errlog_ua_err   = rec.ua;
    assign errlog_syndrome = rec.syn;
    assign errlog_idx      = IDX_W'(rec.idx);

endmodule

// File: tb/tb_sctag_vuad_errlog.sv
// tb/tb_sctag_vuad_errlog.sv - directed self-checking bench for sctag_vuad_errlog
module tb_sctag_vuad_errlog;

    localparam int IDX_W = 10;
    localparam int CNT_W = 8;

    logic             rclk = 1'b0;
    logic             rst;
    logic [3:0]       vuad_syndrome_c9;
    logic             vuad_rd_vld_c9;
    logic [IDX_W-1:0] vuad_idx_c9;
    logic             csr_err_ack;
`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
    logic             errinj_arm;
    logic [3:0]       errinj_mask;
`endif
    logic             errlog_req;
    logic             errlog_vd_err;
    logic             errlog_ua_err;
    logic [3:0]       errlog_syndrome;
    logic [IDX_W-1:0] errlog_idx;
    logic             errlog_ovf;
    logic [CNT_W-1:0] errlog_cnt;
    logic             errlog_fatal;

    int n_pass = 0;
    int n_total = 0;

    always #5 rclk = ~rclk;

    sctag_vuad_errlog #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .rclk             (rclk),
        .rst              (rst),
        .vuad_syndrome_c9 (vuad_syndrome_c9),
        .vuad_rd_vld_c9   (vuad_rd_vld_c9),
        .vuad_idx_c9      (vuad_idx_c9),
`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
        .errinj_arm       (errinj_arm),
        .errinj_mask      (errinj_mask),
`endif
        .csr_err_ack      (csr_err_ack),
        .errlog_req       (errlog_req),
        .errlog_vd_err    (errlog_vd_err),
        .errlog_ua_err    (errlog_ua_err),
        .errlog_syndrome  (errlog_syndrome),
        .errlog_idx       (errlog_idx),
        .errlog_ovf       (errlog_ovf),
        .errlog_cnt       (errlog_cnt),
        .errlog_fatal     (errlog_fatal)
    );

    // Advance one cycle; inputs set afterwards belong to the new cycle, outputs are settled.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [3:0] syn, input logic [IDX_W-1:0] idx);
        vuad_rd_vld_c9   = vld;
        vuad_syndrome_c9 = syn;
        vuad_idx_c9      = idx;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        csr_err_ack = 1'b0;
        drive(1'b0, 4'b0, '0);
`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
        errinj_arm  = 1'b0;
        errinj_mask = 4'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if ({errlog_req, errlog_vd_err, errlog_ua_err, errlog_ovf, errlog_fatal} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {errlog_req, errlog_vd_err, errlog_ua_err, errlog_ovf, errlog_fatal}); else n_pass++;
        n_total++; if ({errlog_syndrome, errlog_idx, errlog_cnt} !== '0) $display("FAIL reset_fields: syn=%h idx=%h cnt=%0d want 0", errlog_syndrome, errlog_idx, errlog_cnt); else n_pass++;
    endtask

    task automatic test_single_error();
        do_reset();
        drive(1'b1, 4'b0100, 10'h155);
        step();
        drive(1'b0, 4'b0, '0);
        n_total++; if (errlog_req !== 1'b0) $display("FAIL single_req_c1: got %b want 0", errlog_req); else n_pass++;
        step();
        n_total++; if (errlog_req !== 1'b1) $display("FAIL single_req_c2: got %b want 1", errlog_req); else n_pass++;
        n_total++; if ({errlog_vd_err, errlog_ua_err} !== 2'b10) $display("FAIL single_class: got %b want 10", {errlog_vd_err, errlog_ua_err}); else n_pass++;
        n_total++; if (errlog_idx !== 10'h155 || errlog_syndrome !== 4'b0100) $display("FAIL single_rec: idx=%h syn=%b want 155/0100", errlog_idx, errlog_syndrome); else n_pass++;
        n_total++; if (errlog_cnt !== 8'd1 || errlog_fatal !== 1'b1) $display("FAIL single_cnt_fatal: cnt=%0d fatal=%b want 1/1", errlog_cnt, errlog_fatal); else n_pass++;
        step();
        n_total++; if (errlog_req !== 1'b1) $display("FAIL single_req_c3: got %b want 1", errlog_req); else n_pass++;
        step();
        n_total++; if (errlog_req !== 1'b1) $display("FAIL single_req_c4: got %b want 1", errlog_req); else n_pass++;
        csr_err_ack = 1'b1;
        step();
        csr_err_ack = 1'b0;
        n_total++; if (errlog_req !== 1'b0) $display("FAIL single_req_c5: got %b want 0", errlog_req); else n_pass++;
        csr_err_ack = 1'b1;
        step();
        csr_err_ack = 1'b0;
        n_total++; if (errlog_req !== 1'b0 || errlog_cnt !== 8'd1) $display("FAIL idle_ack: req=%b cnt=%0d want 0/1", errlog_req, errlog_cnt); else n_pass++;
    endtask

    task automatic test_unqualified();
        do_reset();
        drive(1'b0, 4'b1111, 10'h0AA);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 4'b0, '0);
        n_total++; if (errlog_req !== 1'b0) $display("FAIL unqual_req: got %b want 0", errlog_req); else n_pass++;
        n_total++; if (errlog_cnt !== 8'd0 || errlog_fatal !== 1'b0) $display("FAIL unqual_cnt_fatal: cnt=%0d fatal=%b want 0/0", errlog_cnt, errlog_fatal); else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b1, 4'b0001, 10'h010);
        step();
        drive(1'b1, 4'b0010, 10'h020);
        step();
        drive(1'b0, 4'b0, '0);
        n_total++; if (errlog_ovf !== 1'b0) $display("FAIL ovf_c2: got %b want 0", errlog_ovf); else n_pass++;
        step();
        n_total++; if (errlog_req !== 1'b1 || errlog_ovf !== 1'b1) $display("FAIL ovf_c3: req=%b ovf=%b want 1/1", errlog_req, errlog_ovf); else n_pass++;
        n_total++; if (errlog_idx !== 10'h010 || errlog_syndrome !== 4'b0001) $display("FAIL ovf_rec: idx=%h syn=%b want 010/0001", errlog_idx, errlog_syndrome); else n_pass++;
        n_total++; if ({errlog_vd_err, errlog_ua_err, errlog_fatal} !== 3'b010) $display("FAIL ovf_class: got %b want 010", {errlog_vd_err, errlog_ua_err, errlog_fatal}); else n_pass++;
        n_total++; if (errlog_cnt !== 8'd2) $display("FAIL ovf_cnt: got %0d want 2", errlog_cnt); else n_pass++;
    endtask

    task automatic test_ack_collision();
        do_reset();
        drive(1'b1, 4'b0001, 10'h011);
        step();
        drive(1'b0, 4'b0, '0);
        step();
        step();
        drive(1'b1, 4'b1000, 10'h2AA);
        step();
        drive(1'b0, 4'b0, '0);
        csr_err_ack = 1'b1;
        step();
        csr_err_ack = 1'b0;
        n_total++; if (errlog_req !== 1'b1 || errlog_ovf !== 1'b0) $display("FAIL coll_req_ovf: req=%b ovf=%b want 1/0", errlog_req, errlog_ovf); else n_pass++;
        n_total++; if (errlog_idx !== 10'h2AA || errlog_syndrome !== 4'b1000) $display("FAIL coll_rec: idx=%h syn=%b want 2aa/1000", errlog_idx, errlog_syndrome); else n_pass++;
        n_total++; if ({errlog_vd_err, errlog_ua_err} !== 2'b10 || errlog_cnt !== 8'd2) $display("FAIL coll_class_cnt: class=%b cnt=%0d want 10/2", {errlog_vd_err, errlog_ua_err}, errlog_cnt); else n_pass++;
        csr_err_ack = 1'b1;
        step();
        csr_err_ack = 1'b0;
        n_total++; if (errlog_req !== 1'b0) $display("FAIL coll_release: got %b want 0", errlog_req); else n_pass++;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        drive(1'b1, 4'b0100, 10'h001);
        step();
        drive(1'b1, 4'b0001, 10'h002);
        for (int i = 1; i < 300; i++) step();
        drive(1'b0, 4'b0, '0);
        step();
        step();
        n_total++; if (errlog_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d want 255", errlog_cnt); else n_pass++;
        n_total++; if ({errlog_req, errlog_ovf, errlog_fatal} !== 3'b111) $display("FAIL sat_flags: got %b want 111", {errlog_req, errlog_ovf, errlog_fatal}); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++; if ({errlog_req, errlog_ovf, errlog_fatal} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {errlog_req, errlog_ovf, errlog_fatal}); else n_pass++;
        n_total++; if (errlog_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", errlog_cnt); else n_pass++;
        step();
        step();
        n_total++; if (errlog_req !== 1'b0) $display("FAIL rst_stays_idle: got %b want 0", errlog_req); else n_pass++;
    endtask

`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
    task automatic test_injection();
        do_reset();
        errinj_arm  = 1'b1;
        errinj_mask = 4'b1000;
        step();
        errinj_arm  = 1'b0;
        errinj_mask = 4'b0;
        drive(1'b1, 4'b0, 10'h3FF);
        step();
        drive(1'b1, 4'b0, 10'h001);
        step();
        drive(1'b0, 4'b0, '0);
        step();
        n_total++; if (errlog_req !== 1'b1 || errlog_vd_err !== 1'b1) $display("FAIL inj_req_vd: req=%b vd=%b want 1/1", errlog_req, errlog_vd_err); else n_pass++;
        n_total++; if (errlog_syndrome !== 4'b1000 || errlog_idx !== 10'h3FF) $display("FAIL inj_rec: syn=%b idx=%h want 1000/3ff", errlog_syndrome, errlog_idx); else n_pass++;
        step();
        n_total++; if (errlog_cnt !== 8'd1 || errlog_ovf !== 1'b0) $display("FAIL inj_once: cnt=%0d ovf=%b want 1/0", errlog_cnt, errlog_ovf); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_error();
        test_unqualified();
        test_overflow();
        test_ack_collision();
        test_saturation_reset();
`ifdef SCTAG_VUAD_ERRLOG_INJ_EN
        test_injection();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
